// File: rtl/streamer_block_checker.sv
// Client-side consumer for the rx_streamer: checks block framing and an
// incrementing-counter payload, and keeps saturating link statistics.
module streamer_block_checker #(
  parameter int unsigned g_data_width     = 64,
  parameter int unsigned g_block_size_max = 3,
  parameter int unsigned g_cnt_width      = 32
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    clear_i,
  input  logic [g_data_width-1:0] rx_data_i,
  input  logic                    rx_valid_i,
  input  logic                    rx_first_p1_i,
  input  logic                    rx_last_p1_i,
  input  logic                    rx_lost_p1_i,
  output logic                    rx_dreq_o,
  output logic [g_cnt_width-1:0]  words_o,
  output logic [g_cnt_width-1:0]  blocks_ok_o,
  output logic [g_cnt_width-1:0]  seq_err_o,
  output logic [g_cnt_width-1:0]  frame_err_o,
  output logic [g_cnt_width-1:0]  lost_o,
  output logic                    err_p1_o,
  output logic [g_data_width-1:0] last_bad_data_o
);

  // Block counter saturates one above the limit so the overrun is flagged once.
  localparam int unsigned BC_W = $clog2(g_block_size_max + 2);

  localparam logic [g_cnt_width-1:0]  CNT_ZERO  = {g_cnt_width{1'b0}};
  localparam logic [g_cnt_width-1:0]  CNT_MAX   = {g_cnt_width{1'b1}};
  localparam logic [g_cnt_width-1:0]  CNT_ONE   = {{(g_cnt_width-1){1'b0}}, 1'b1};
  localparam logic [g_data_width-1:0] DATA_ZERO = {g_data_width{1'b0}};
  localparam logic [g_data_width-1:0] DATA_ONE  = {{(g_data_width-1){1'b0}}, 1'b1};
  localparam logic [BC_W-1:0]         BC_ZERO   = {BC_W{1'b0}};
  localparam logic [BC_W-1:0]         BC_ONE    = {{(BC_W-1){1'b0}}, 1'b1};
  localparam logic [BC_W-1:0]         BC_LIMIT  = BC_W'(g_block_size_max);
  localparam logic [BC_W-1:0]         BC_SAT    = BC_W'(g_block_size_max + 1);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_IN_BLOCK = 1'b1
  } state_t;

  function automatic logic [g_cnt_width-1:0] sat_inc(input logic [g_cnt_width-1:0] v);
    logic [g_cnt_width-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  state_t                  state_q, state_d;
  logic                    sync_q, sync_d;
  logic [g_data_width-1:0] exp_q, exp_d;
  logic [BC_W-1:0]         bc_q, bc_d;
  logic                    bad_q, bad_d;
  logic                    dreq_q, dreq_d;
  logic [g_cnt_width-1:0]  words_q, words_d;
  logic [g_cnt_width-1:0]  blocks_ok_q, blocks_ok_d;
  logic [g_cnt_width-1:0]  seq_err_q, seq_err_d;
  logic [g_cnt_width-1:0]  frame_err_q, frame_err_d;
  logic [g_cnt_width-1:0]  lost_q, lost_d;
  logic                    err_q, err_d;
  logic [g_data_width-1:0] last_bad_q, last_bad_d;

  logic seq_hit;
  logic frame_hit;
  logic over_hit;
  logic bad_n;
  logic done_ok;

  // State register with synchronous reset.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      sync_q      <= 1'b0;
      exp_q       <= DATA_ZERO;
      bc_q        <= BC_ZERO;
      bad_q       <= 1'b0;
      dreq_q      <= 1'b0;
      words_q     <= CNT_ZERO;
      blocks_ok_q <= CNT_ZERO;
      seq_err_q   <= CNT_ZERO;
      frame_err_q <= CNT_ZERO;
      lost_q      <= CNT_ZERO;
      err_q       <= 1'b0;
      last_bad_q  <= DATA_ZERO;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      exp_q       <= exp_d;
      bc_q        <= bc_d;
      bad_q       <= bad_d;
      dreq_q      <= dreq_d;
      words_q     <= words_d;
      blocks_ok_q <= blocks_ok_d;
      seq_err_q   <= seq_err_d;
      frame_err_q <= frame_err_d;
      lost_q      <= lost_d;
      err_q       <= err_d;
      last_bad_q  <= last_bad_d;
    end
  end

  // Next-state: lost event first, then the record against the updated state.
  always_comb begin
    state_d     = state_q;
    sync_d      = sync_q;
    exp_d       = exp_q;
    bc_d        = bc_q;
    bad_d       = bad_q;
    dreq_d      = enable_i;
    words_d     = words_q;
    blocks_ok_d = blocks_ok_q;
    seq_err_d   = seq_err_q;
    frame_err_d = frame_err_q;
    lost_d      = lost_q;
    err_d       = 1'b0;
    last_bad_d  = last_bad_q;
    seq_hit     = 1'b0;
    frame_hit   = 1'b0;
    over_hit    = 1'b0;
    bad_n       = 1'b0;
    done_ok     = 1'b0;

    if (rx_lost_p1_i) begin
      lost_d  = sat_inc(lost_q);
      sync_d  = 1'b0;
      state_d = ST_IDLE;
      bc_d    = BC_ZERO;
      bad_d   = 1'b0;
    end else begin
      lost_d  = lost_q;
    end

    if (rx_valid_i) begin
      words_d = sat_inc(words_q);
      seq_hit = sync_d & (rx_data_i != exp_q);
      exp_d   = rx_data_i + DATA_ONE;
      sync_d  = 1'b1;

      // An unexpected first in IN_BLOCK abandons the old block and starts a new one.
      if (rx_first_p1_i) begin
        if (state_d == ST_IN_BLOCK) begin
          frame_hit = 1'b1;
        end else begin
          frame_hit = 1'b0;
        end
        if (rx_last_p1_i) begin
          done_ok = ~seq_hit;
          state_d = ST_IDLE;
          bc_d    = BC_ZERO;
          bad_d   = 1'b0;
        end else begin
          state_d = ST_IN_BLOCK;
          bc_d    = BC_ONE;
          bad_d   = seq_hit;
        end
      end else begin
        case (state_d)
          ST_IDLE: begin
            frame_hit = 1'b1;
          end
          ST_IN_BLOCK: begin
            over_hit  = (bc_d == BC_LIMIT);
            frame_hit = over_hit;
            bad_n     = bad_d | seq_hit | over_hit;
            if (rx_last_p1_i) begin
              done_ok = ~bad_n;
              state_d = ST_IDLE;
              bc_d    = BC_ZERO;
              bad_d   = 1'b0;
            end else begin
              if (bc_d == BC_SAT) begin
                bc_d = bc_d;
              end else begin
                bc_d = bc_d + BC_ONE;
              end
              bad_d = bad_n;
            end
          end
          default: begin
            state_d = ST_IDLE;
            bc_d    = BC_ZERO;
            bad_d   = 1'b0;
          end
        endcase
      end
    end else begin
      words_d = words_q;
    end

    if (seq_hit) begin
      seq_err_d  = sat_inc(seq_err_q);
      last_bad_d = rx_data_i;
    end else begin
      seq_err_d  = seq_err_q;
    end

    if (frame_hit) begin
      frame_err_d = sat_inc(frame_err_q);
    end else begin
      frame_err_d = frame_err_q;
    end

    if (done_ok) begin
      blocks_ok_d = sat_inc(blocks_ok_q);
    end else begin
      blocks_ok_d = blocks_ok_q;
    end

    err_d = seq_hit | frame_hit;

    // Clear overrides any same-cycle increment but leaves the tracking state alone.
    if (clear_i) begin
      words_d     = CNT_ZERO;
      blocks_ok_d = CNT_ZERO;
      seq_err_d   = CNT_ZERO;
      frame_err_d = CNT_ZERO;
      lost_d      = CNT_ZERO;
      err_d       = 1'b0;
      last_bad_d  = DATA_ZERO;
    end else begin
      err_d       = err_d;
    end
  end

  assign rx_dreq_o       = dreq_q;
  assign words_o         = words_q;
  assign blocks_ok_o     = blocks_ok_q;
  assign seq_err_o       = seq_err_q;
  assign frame_err_o     = frame_err_q;
  assign lost_o          = lost_q;
  assign err_p1_o        = err_q;
  assign last_bad_data_o = last_bad_q;

endmodule
